// File: rtl/grid_env_step_if.sv
// Handshake bundle between the action selector, the grid step block and the Q-update stage.
// The slave side is the step block; the master side is its environment.
interface grid_env_step_if;
    logic       act_valid;
    logic       act_ready;
    logic [1:0] action;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] out_action;
    logic [2:0] next_row;
    logic [2:0] next_col;
    logic [7:0] reward;
    logic       done;

    modport master (
        output act_valid,
        output action,
        output out_ready,
        input  act_ready,
        input  out_valid,
        input  row,
        input  col,
        input  out_action,
        input  next_row,
        input  next_col,
        input  reward,
        input  done
    );

    modport slave (
        input  act_valid,
        input  action,
        input  out_ready,
        output act_ready,
        output out_valid,
        output row,
        output col,
        output out_action,
        output next_row,
        output next_col,
        output reward,
        output done
    );
endinterface

// File: rtl/grid_env_step.sv
// Grid-world environment step: accepts one action, registers the resulting transition,
// and holds it until the Q-update stage consumes it, then commits the move.
module grid_env_step #(
    parameter int unsigned ROWS        = 5,
    parameter int unsigned COLS        = 5,
    parameter int unsigned START_ROW   = 0,
    parameter int unsigned START_COL   = 0,
    parameter int unsigned GOAL_ROW    = 4,
    parameter int unsigned GOAL_COL    = 4,
    parameter int unsigned GOAL_REWARD = 100,
    parameter int unsigned STEP_REWARD = 1,
    parameter int unsigned WALL_REWARD = 0,
    parameter int unsigned MAX_STEPS   = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    grid_env_step_if.slave       bus,
    output logic [2:0]           cur_row,
    output logic [2:0]           cur_col,
    output logic [7:0]           step_count,
    output logic [15:0]          episode_count
);

    localparam logic [2:0] RowMax   = 3'(ROWS - 1);
    localparam logic [2:0] ColMax   = 3'(COLS - 1);
    localparam logic [2:0] StartRow = 3'(START_ROW);
    localparam logic [2:0] StartCol = 3'(START_COL);
    localparam logic [2:0] GoalRow  = 3'(GOAL_ROW);
    localparam logic [2:0] GoalCol  = 3'(GOAL_COL);
    localparam logic [7:0] GoalRew  = 8'(GOAL_REWARD);
    localparam logic [7:0] StepRew  = 8'(STEP_REWARD);
    localparam logic [7:0] WallRew  = 8'(WALL_REWARD);
    localparam logic [8:0] StepLim  = 9'(MAX_STEPS);

    typedef enum logic {StReady, StHold} state_e;

    state_e state_q, state_d;

    logic [2:0]  row_q, col_q, next_row_q, next_col_q;
    logic [1:0]  action_q;
    logic [7:0]  reward_q;
    logic        done_q;
    logic [2:0]  cur_row_q, cur_col_q;
    logic [7:0]  step_count_q;
    logic [15:0] episode_count_q;

    logic        accept, commit;
    logic [2:0]  mv_row, mv_col;
    logic        mv_blocked, mv_goal, mv_done;
    logic [7:0]  mv_reward;

    // clear masks both handshakes so a coinciding accept or commit is dropped
    assign accept = (state_q == StReady) && bus.act_valid && !clear;
    assign commit = (state_q == StHold) && bus.out_ready && !clear;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReady;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StReady;
        end else begin
            case (state_q)
                StReady: if (bus.act_valid) state_d = StHold;
                StHold:  if (bus.out_ready) state_d = StReady;
                default: state_d = StReady;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        bus.act_ready = (state_q == StReady);
        bus.out_valid = (state_q == StHold);
    end

    // Move evaluation from the committed position; edge moves stay in place
    always_comb begin
        mv_row     = cur_row_q;
        mv_col     = cur_col_q;
        mv_blocked = 1'b0;
        case (bus.action)
            2'd0: begin
                if (cur_row_q == 3'd0) mv_blocked = 1'b1;
                else                   mv_row = cur_row_q - 3'd1;
            end
            2'd1: begin
                if (cur_row_q >= RowMax) mv_blocked = 1'b1;
                else                     mv_row = cur_row_q + 3'd1;
            end
            2'd2: begin
                if (cur_col_q == 3'd0) mv_blocked = 1'b1;
                else                   mv_col = cur_col_q - 3'd1;
            end
            default: begin
                if (cur_col_q >= ColMax) mv_blocked = 1'b1;
                else                     mv_col = cur_col_q + 3'd1;
            end
        endcase

        mv_goal = (mv_row == GoalRow) && (mv_col == GoalCol);

        if (mv_goal)         mv_reward = GoalRew;
        else if (mv_blocked) mv_reward = WallRew;
        else                 mv_reward = StepRew;

        mv_done = mv_goal || (({1'b0, step_count_q} + 9'd1) == StepLim);
    end

    // Transition and episode datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q           <= 3'd0;
            col_q           <= 3'd0;
            action_q        <= 2'd0;
            next_row_q      <= 3'd0;
            next_col_q      <= 3'd0;
            reward_q        <= 8'd0;
            done_q          <= 1'b0;
            cur_row_q       <= StartRow;
            cur_col_q       <= StartCol;
            step_count_q    <= 8'd0;
            episode_count_q <= 16'd0;
        end else if (clear) begin
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            action_q     <= 2'd0;
            next_row_q   <= 3'd0;
            next_col_q   <= 3'd0;
            reward_q     <= 8'd0;
            done_q       <= 1'b0;
            cur_row_q    <= StartRow;
            cur_col_q    <= StartCol;
            step_count_q <= 8'd0;
        end else begin
            if (accept) begin
                row_q      <= cur_row_q;
                col_q      <= cur_col_q;
                action_q   <= bus.action;
                next_row_q <= mv_row;
                next_col_q <= mv_col;
                reward_q   <= mv_reward;
                done_q     <= mv_done;
            end
            if (commit) begin
                if (done_q) begin
                    cur_row_q       <= StartRow;
                    cur_col_q       <= StartCol;
                    step_count_q    <= 8'd0;
                    episode_count_q <= episode_count_q + 16'd1;
                end else begin
                    cur_row_q    <= next_row_q;
                    cur_col_q    <= next_col_q;
                    step_count_q <= step_count_q + 8'd1;
                end
            end
        end
    end

    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.out_action = action_q;
    assign bus.next_row   = next_row_q;
    assign bus.next_col   = next_col_q;
    assign bus.reward     = reward_q;
    assign bus.done       = done_q;

    assign cur_row       = cur_row_q;
    assign cur_col       = cur_col_q;
    assign step_count    = step_count_q;
    assign episode_count = episode_count_q;

    // A stalled transition must not change under the consumer
    hold_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == StHold && !bus.out_ready && !clear) |=>
        (state_q == StHold &&
         $stable({row_q, col_q, action_q, next_row_q, next_col_q, reward_q, done_q})));

    pos_in_grid: assert property (@(posedge clk) disable iff (rst)
        (cur_row_q <= RowMax) && (cur_col_q <= ColMax));

endmodule

// File: tb/tb_grid_env_step.sv
// Directed bench for grid_env_step: a table of single-step transitions walked from reset,
// plus hand-written sequences for stalls, step limit, clear and reset corner cases.
module tb_grid_env_step;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [2:0]  cur_row, cur_col;
    logic [7:0]  step_count;
    logic [15:0] episode_count;

    int total = 0;
    int bad   = 0;

    grid_env_step_if bus ();

    grid_env_step dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .bus           (bus),
        .cur_row       (cur_row),
        .cur_col       (cur_col),
        .step_count    (step_count),
        .episode_count (episode_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  act;
        logic [2:0]  r, c, nr, nc;
        logic [7:0]  rew;
        logic        done;
        logic [2:0]  cr, cc;
        logic [7:0]  sc;
        logic [15:0] ep;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Present one action for a single edge once the block is ready
    task automatic offer(input logic [1:0] a);
        int n = 0;
        while (!bus.act_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("act_ready_before_offer", bus.act_ready, 1);
        bus.act_valid = 1'b1;
        bus.action    = a;
        @(posedge clk);
        #1;
        bus.act_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              act   r     c     nr    nc    rew     dn    cr    cc    sc     ep
        vecs[0]  = '{2'd3, 3'd0, 3'd0, 3'd0, 3'd1, 8'd1,   1'b0, 3'd0, 3'd1, 8'd1,  16'd0};
        vecs[1]  = '{2'd0, 3'd0, 3'd1, 3'd0, 3'd1, 8'd0,   1'b0, 3'd0, 3'd1, 8'd2,  16'd0};
        vecs[2]  = '{2'd2, 3'd0, 3'd1, 3'd0, 3'd0, 8'd1,   1'b0, 3'd0, 3'd0, 8'd3,  16'd0};
        vecs[3]  = '{2'd2, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0,   1'b0, 3'd0, 3'd0, 8'd4,  16'd0};
        vecs[4]  = '{2'd1, 3'd0, 3'd0, 3'd1, 3'd0, 8'd1,   1'b0, 3'd1, 3'd0, 8'd5,  16'd0};
        vecs[5]  = '{2'd1, 3'd1, 3'd0, 3'd2, 3'd0, 8'd1,   1'b0, 3'd2, 3'd0, 8'd6,  16'd0};
        vecs[6]  = '{2'd1, 3'd2, 3'd0, 3'd3, 3'd0, 8'd1,   1'b0, 3'd3, 3'd0, 8'd7,  16'd0};
        vecs[7]  = '{2'd1, 3'd3, 3'd0, 3'd4, 3'd0, 8'd1,   1'b0, 3'd4, 3'd0, 8'd8,  16'd0};
        vecs[8]  = '{2'd1, 3'd4, 3'd0, 3'd4, 3'd0, 8'd0,   1'b0, 3'd4, 3'd0, 8'd9,  16'd0};
        vecs[9]  = '{2'd3, 3'd4, 3'd0, 3'd4, 3'd1, 8'd1,   1'b0, 3'd4, 3'd1, 8'd10, 16'd0};
        vecs[10] = '{2'd3, 3'd4, 3'd1, 3'd4, 3'd2, 8'd1,   1'b0, 3'd4, 3'd2, 8'd11, 16'd0};
        vecs[11] = '{2'd3, 3'd4, 3'd2, 3'd4, 3'd3, 8'd1,   1'b0, 3'd4, 3'd3, 8'd12, 16'd0};
        vecs[12] = '{2'd3, 3'd4, 3'd3, 3'd4, 3'd4, 8'd100, 1'b1, 3'd0, 3'd0, 8'd0,  16'd1};
        vecs[13] = '{2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0,   1'b0, 3'd0, 3'd0, 8'd1,  16'd1};

        rst           = 1'b1;
        clear         = 1'b0;
        bus.act_valid = 1'b0;
        bus.action    = 2'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_act_ready", bus.act_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_cur_row", cur_row, 0);
        check("rst_cur_col", cur_col, 0);
        check("rst_step", step_count, 0);
        check("rst_episode", episode_count, 0);
        check("rst_reward", bus.reward, 0);
        check("rst_next_col", bus.next_col, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            offer(vecs[i].act);
            check("vec_out_valid", bus.out_valid, 1);
            check("vec_act_ready", bus.act_ready, 0);
            check("vec_row", bus.row, vecs[i].r);
            check("vec_col", bus.col, vecs[i].c);
            check("vec_out_action", bus.out_action, vecs[i].act);
            check("vec_next_row", bus.next_row, vecs[i].nr);
            check("vec_next_col", bus.next_col, vecs[i].nc);
            check("vec_reward", bus.reward, vecs[i].rew);
            check("vec_done", bus.done, vecs[i].done);
            handshake();
            check("vec_post_out_valid", bus.out_valid, 0);
            check("vec_cur_row", cur_row, vecs[i].cr);
            check("vec_cur_col", cur_col, vecs[i].cc);
            check("vec_step", step_count, vecs[i].sc);
            check("vec_episode", episode_count, vecs[i].ep);
        end

        // Stall in HOLD with act_valid/action wiggling: nothing may move
        offer(2'd1);
        for (int k = 0; k < 5; k++) begin
            bus.act_valid = k[0];
            bus.action    = k[1:0];
            @(posedge clk);
            #1;
            check("stall_act_ready", bus.act_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_next_row", bus.next_row, 1);
            check("stall_out_action", bus.out_action, 1);
            check("stall_reward", bus.reward, 1);
            check("stall_cur_row", cur_row, 0);
            check("stall_step", step_count, 1);
        end
        bus.act_valid = 1'b0;
        handshake();
        check("stall_commit_row", cur_row, 1);
        check("stall_commit_step", step_count, 2);
        @(posedge clk);
        #1;
        check("stall_single_commit", step_count, 2);
        check("stall_idle_valid", bus.out_valid, 0);

        // clear coinciding with action acceptance: nothing accepted
        bus.act_valid = 1'b1;
        bus.action    = 2'd1;
        clear         = 1'b1;
        @(posedge clk);
        #1;
        clear         = 1'b0;
        bus.act_valid = 1'b0;
        check("clr_acc_out_valid", bus.out_valid, 0);
        check("clr_acc_act_ready", bus.act_ready, 1);
        check("clr_acc_cur_row", cur_row, 0);
        check("clr_acc_step", step_count, 0);
        check("clr_acc_episode", episode_count, 1);

        // Walk to 2/2, then clear together with the out handshake
        offer(2'd1); handshake();
        offer(2'd1); handshake();
        offer(2'd3); handshake();
        offer(2'd3); handshake();
        check("walk_cur_row", cur_row, 2);
        check("walk_cur_col", cur_col, 2);
        check("walk_step", step_count, 4);
        offer(2'd0);
        check("walk_next_row", bus.next_row, 1);
        clear         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear         = 1'b0;
        bus.out_ready = 1'b0;
        check("clr_hs_out_valid", bus.out_valid, 0);
        check("clr_hs_cur_row", cur_row, 0);
        check("clr_hs_cur_col", cur_col, 0);
        check("clr_hs_step", step_count, 0);
        check("clr_hs_episode", episode_count, 1);

        // Step limit: 31 wall bumps end the episode
        for (int i = 0; i < 31; i++) begin
            offer(2'd2);
            check("limit_reward", bus.reward, 0);
            check("limit_done", bus.done, (i == 30) ? 1 : 0);
            handshake();
        end
        check("limit_episode", episode_count, 2);
        check("limit_step", step_count, 0);
        check("limit_cur_col", cur_col, 0);

        // Reset while a transition is pending
        offer(2'd3);
        check("prerst_out_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_act_ready", bus.act_ready, 1);
        check("midrst_next_col", bus.next_col, 0);
        check("midrst_episode", episode_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        offer(2'd1);
        check("postrst_row", bus.row, 0);
        check("postrst_col", bus.col, 0);
        check("postrst_next_row", bus.next_row, 1);
        handshake();
        check("postrst_step", step_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_env_step.md
GRID_ENV_STEP -- requirements
Module: grid_env_step

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  ROWS, 5, grid rows
  COLS, 5, grid columns
  START_ROW, 0, episode start row
  START_COL, 0, episode start column
  GOAL_ROW, 4, terminal goal row
  GOAL_COL, 4, terminal goal column
  GOAL_REWARD, 100, reward on entering goal
  STEP_REWARD, 1, reward on a non-goal in-bounds move
  WALL_REWARD, 0, reward on a move blocked by the grid edge
  MAX_STEPS, 31, step limit per episode, legal range 1..255
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  clock
  rst  in  1  reset, asynchronous, active-high
  clear  in  1  synchronous episode restart
  act_valid  in  1  action offered by selector
  act_ready  out  1  block accepts an action
  action  in  2  0 up (row-1), 1 down (row+1), 2 left (col-1), 3 right (col+1)
  out_valid  out  1  transition available to the Q-update stage
  out_ready  in  1  Q-update stage consumes the transition
  row, col  out  3 each  state before the move
  out_action  out  2  action taken
  next_row, next_col  out  3 each  state after the move
  reward  out  8  unsigned reward
  done  out  1  the transition ends the episode
  cur_row, cur_col  out  3 each  current agent position
  step_count  out  8  steps committed in the current episode
  episode_count  out  16  episodes completed

Function
REQ-003 The FSM SHALL have two states: READY (act_ready=1, out_valid=0) and HOLD (act_ready=0, out_valid=1).
REQ-004 In READY, act_valid=1 SHALL accept the action and move the FSM to HOLD on the next edge; the transition outputs SHALL be registered and valid on that edge, giving 1-cycle latency.
REQ-005 Next-state computation: move by one cell per REQ-002; a move that would leave [0,ROWS-1]x[0,COLS-1] SHALL leave next = current.
REQ-006 The reward SHALL be GOAL_REWARD if the next position equals (GOAL_ROW,GOAL_COL); otherwise WALL_REWARD if the move was blocked; otherwise STEP_REWARD.
REQ-007 done SHALL be 1 if the next position equals the goal, or if step_count+1 == MAX_STEPS.
REQ-008 In HOLD, row/col/out_action/next_row/next_col/reward/done SHALL remain stable until out_valid&&out_ready.
REQ-009 On out_valid&&out_ready with done=0, the block SHALL set cur = next, increment step_count, and return to READY.
REQ-010 On out_valid&&out_ready with done=1, the block SHALL set cur = (START_ROW,START_COL), set step_count to 0, increment episode_count (wrapping 0xFFFF->0), and return to READY.
REQ-011 Throughput SHALL be at most one transition per 2 cycles; act_valid in HOLD SHALL be ignored.
REQ-012 clear SHALL have priority in either state: the block SHALL discard any pending transition, set out_valid=0, cur=start, step_count=0 and state=READY, and leave episode_count unchanged.
REQ-013 When clear coincides with an out handshake or with action acceptance, clear SHALL win and the transition SHALL NOT be committed.
REQ-014 When the agent sits at the goal, e.g. START equals GOAL, moves SHALL still be evaluated normally per REQ-005..REQ-007.

Reset
REQ-015 While rst=1, the block SHALL set: state READY, act_ready=1, out_valid=0, cur_row=START_ROW, cur_col=START_COL, step_count=0, episode_count=0, and all transition outputs 0.
REQ-016 Deassertion of rst mid-HOLD SHALL leave no pending transition; the first accept after reset SHALL start from the start position.

Verification
REQ-017 Reset, then action=3 with out_ready=1 -> out_valid 1 cycle after accept; row/col=0/0, next=0/1, reward=1, done=0; then cur=0/1, step_count=1.
REQ-018 From 0/0, action=0 -> next=0/0, reward=0 (WALL_REWARD), done=0, step_count=1.
REQ-019 From 4/3, action=3 -> next=4/4, reward=100, done=1; after handshake cur=0/0, step_count=0, episode_count=1.
REQ-020 Hold out_ready=0 for 5 cycles in HOLD while toggling act_valid/action -> outputs stable, act_ready=0, no state change; out_ready=1 -> single commit.
REQ-021 Issue 31 wall-bumping actions (action=2 at 0/0) -> 31st transition has done=1, reward=0; afterwards episode_count increments and step_count=0.
REQ-022 Assert clear in HOLD together with out_ready=1 at position 2/2 -> out_valid=0 next cycle, cur=0/0, step_count=0, episode_count unchanged.
